// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the serial adder/subtractor.
// The master drives the request side; the slave returns status and result.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output start, op, A, B, Cin,
        input  ready, done, Sum, Cout, Ovf
    );

    modport slave (
        input  start, op, A, B, Cin,
        output ready, done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock, LSB chunk first,
// registered carry between chunks, start/ready/done handshake.
module serial_addsub #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic           clk,
    input logic           rst,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int BM = BITS_PER_CYCLE - 1;

    generate
        if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
            $error("serial_addsub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]                a_sh;
    logic [WIDTH-1:0]                b_sh;
    logic [WIDTH-1:0]                work;
    logic                            carry;
    logic [CW-1:0]                   k;
    logic [BITS_PER_CYCLE-1:0]       a_chunk;
    logic [BITS_PER_CYCLE-1:0]       b_chunk;
    logic [BITS_PER_CYCLE-1:0]       s_chunk;
    logic                            c_chunk;
    logic                            c_msb;
    logic                            last;
    logic [WIDTH+BITS_PER_CYCLE-1:0] work_cat;

    // Carry into a chunk's top bit is recovered from that bit's sum and operands.
    always_comb begin
        a_chunk            = a_sh[BM:0];
        b_chunk            = b_sh[BM:0];
        {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk}
                           + {{BITS_PER_CYCLE{1'b0}}, carry};
        c_msb              = s_chunk[BM] ^ a_chunk[BM] ^ b_chunk[BM];
        work_cat           = {s_chunk, work};
        last               = (k == CW'(N - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN:  if (last)      state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state == IDLE);
    end

    // op is folded into the latched B and initial carry rather than stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            work     <= '0;
            carry    <= 1'b0;
            k        <= '0;
            bus.Sum  <= '0;
            bus.Cout <= 1'b0;
            bus.Ovf  <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.op ? ~bus.B : bus.B;
                        carry <= bus.op ? ~bus.Cin : bus.Cin;
                        k     <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> BITS_PER_CYCLE;
                    b_sh  <= b_sh >> BITS_PER_CYCLE;
                    work  <= work_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
                    carry <= c_chunk;
                    k     <= k + CW'(1);
                    if (last) begin
                        bus.Sum  <= work_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
                        bus.Cout <= c_chunk;
                        bus.Ovf  <= c_chunk ^ c_msb;
                        bus.done <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: directed and random 8-bit/1-bit-per-cycle operations,
// plus an exhaustive sweep of a 4-bit/2-bit-per-cycle instance.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst8;
    logic rst4;
    int   checks = 0;
    int   errors = 0;

    serial_addsub_if #(.WIDTH(8)) bus8();
    serial_addsub_if #(.WIDTH(4)) bus4();

    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (bus8)
    );

    serial_addsub #(.WIDTH(4), .BITS_PER_CYCLE(2)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result for Sum/Cout, signed result for Ovf.
    function automatic void model(input int w, input logic o, input int a, input int b,
                                  input logic c, output int sum, output logic cout,
                                  output logic ovf);
        int m, sa, sb, ci, u, sr;
        m  = 1 << w;
        ci = c ? 1 : 0;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        if (!o) begin
            u    = a + b + ci;
            sr   = sa + sb + ci;
            cout = (u >= m);
        end else begin
            u    = a - b - ci;
            sr   = sa - sb - ci;
            cout = (u >= 0);
        end
        sum = ((u % m) + m) % m;
        ovf = (sr < -(m / 2)) || (sr > (m / 2) - 1);
    endfunction

    task automatic issue8(input logic o, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input bit hold);
        @(negedge clk);
        check("ready_idle8", {31'd0, bus8.ready}, 32'd1);
        bus8.start = 1'b1;
        bus8.op    = o;
        bus8.A     = a;
        bus8.B     = b;
        bus8.Cin   = c;
        @(negedge clk);
        if (!hold) bus8.start = 1'b0;
        check("ready_busy8", {31'd0, bus8.ready}, 32'd0);
    endtask

    task automatic wait_done8(output int edges);
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (bus8.done !== 1'b1 && edges < 20);
    endtask

    task automatic check8(input string tag, input logic o, input logic [7:0] a,
                          input logic [7:0] b, input logic c, input int edges);
        int   s;
        logic co, ov;
        model(8, o, int'(a), int'(b), c, s, co, ov);
        check({tag, "_latency"}, edges, 32'd8);
        check({tag, "_sum"}, {24'd0, bus8.Sum}, s);
        check({tag, "_cout"}, {31'd0, bus8.Cout}, {31'd0, co});
        check({tag, "_ovf"}, {31'd0, bus8.Ovf}, {31'd0, ov});
        check({tag, "_ready"}, {31'd0, bus8.ready}, 32'd1);
    endtask

    task automatic run4(input logic o, input logic [3:0] a, input logic [3:0] b, input logic c);
        int   edges, s;
        logic co, ov;
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.op    = o;
        bus4.A     = a;
        bus4.B     = b;
        bus4.Cin   = c;
        @(negedge clk);
        bus4.start = 1'b0;
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (bus4.done !== 1'b1 && edges < 10);
        model(4, o, int'(a), int'(b), c, s, co, ov);
        check($sformatf("w4_op%0d_a%0h_b%0h_c%0d", o, a, b, c),
              {18'd0, edges[7:0], bus4.ready, bus4.Ovf, bus4.Cout, bus4.Sum},
              {18'd0, 8'd2, 1'b1, ov, co, s[3:0]});
    endtask

    initial begin
        int         e;
        int         dones;
        logic       ro;
        logic       rc;
        logic [7:0] ra;
        logic [7:0] rb;

        rst8 = 1'b1;
        rst4 = 1'b1;
        bus8.start = 1'b0; bus8.op = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0;
        bus4.start = 1'b0; bus4.op = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Cin = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, bus8.ready}, 32'd1);
        check("rst_done", {31'd0, bus8.done}, 32'd0);
        check("rst_sum", {24'd0, bus8.Sum}, 32'd0);
        check("rst_cout_ovf", {30'd0, bus8.Cout, bus8.Ovf}, 32'd0);
        rst8 = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, bus8.ready}, 32'd1);
        check("post_rst_done", {31'd0, bus8.done}, 32'd0);

        issue8(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done8(e);
        check8("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, e);
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus8.done}, 32'd0);
        check("sum_held", {23'd0, bus8.Cout, bus8.Sum}, 32'h100);

        issue8(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done8(e);
        check8("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, e);
        issue8(1'b1, 8'h80, 8'h01, 1'b0, 1'b0);
        wait_done8(e);
        check8("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, e);
        issue8(1'b1, 8'h05, 8'h07, 1'b0, 1'b0);
        wait_done8(e);
        check8("sub_05_07", 1'b1, 8'h05, 8'h07, 1'b0, e);
        issue8(1'b1, 8'h10, 8'h03, 1'b1, 1'b0);
        wait_done8(e);
        check8("sub_10_03_b", 1'b1, 8'h10, 8'h03, 1'b1, e);

        // start stays high through RUN with new operands, then is taken in the done cycle
        issue8(1'b0, 8'h12, 8'h34, 1'b0, 1'b1);
        bus8.op = 1'b1; bus8.A = 8'h55; bus8.B = 8'h0F; bus8.Cin = 1'b1;
        wait_done8(e);
        check8("busy_start_ignored", 1'b0, 8'h12, 8'h34, 1'b0, e);
        @(negedge clk);
        bus8.start = 1'b0;
        check("b2b_done_low", {31'd0, bus8.done}, 32'd0);
        check("b2b_accepted", {31'd0, bus8.ready}, 32'd0);
        wait_done8(e);
        check8("back_to_back", 1'b1, 8'h55, 8'h0F, 1'b1, e);

        issue8(1'b0, 8'h21, 8'h42, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        #1;
        check("abort_ready", {31'd0, bus8.ready}, 32'd1);
        check("abort_sum", {24'd0, bus8.Sum}, 32'd0);
        check("abort_cout_ovf", {30'd0, bus8.Cout, bus8.Ovf}, 32'd0);
        check("abort_done", {31'd0, bus8.done}, 32'd0);
        @(negedge clk);
        rst8 = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        issue8(1'b0, 8'h03, 8'h04, 1'b0, 1'b0);
        wait_done8(e);
        check8("add_after_abort", 1'b0, 8'h03, 8'h04, 1'b0, e);

        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            issue8(ro, ra, rb, rc, 1'b0);
            wait_done8(e);
            check8($sformatf("rand%0d", i), ro, ra, rb, rc, e);
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    for (int o = 0; o < 2; o++)
                        run4(1'(o), 4'(a), 4'(b), 1'(c));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor for the calculator datapath; successor to the combinational one-bit full adder.
- Processes operands BITS_PER_CYCLE bits per clock, LSB chunk first, with a registered carry between chunks.
- Uses a start/ready/done handshake and supports add and subtract modes with carry/borrow-in, carry-out and signed overflow.
- Sits between the operand registers and the result register of the calculator.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.
- BITS_PER_CYCLE, 1, bits summed per clock; must divide WIDTH exactly, and this is checked at elaboration.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- op  input  1  0 = add, 1 = subtract; sampled with start
- A  input  WIDTH  operand A; sampled with start
- B  input  WIDTH  operand B; sampled with start
- Cin  input  1  carry-in for add, borrow-in for subtract; sampled with start
- ready  output  1  block idle, so start will be accepted
- done  output  1  one-cycle pulse; result outputs are updated in this cycle
- Sum  output  WIDTH  result
- Cout  output  1  add: carry-out; subtract: 1 = no borrow, 0 = borrow
- Ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: asynchronous and active-high. While rst=1 and after release:
  - state=IDLE, ready=1, done=0
  - Sum=0, Cout=0, Ovf=0
  - internal chunk counter and carry cleared
- FSM states are IDLE and RUN. ready is 1 exactly when state=IDLE.
- IDLE to RUN on a rising edge with start=1:
  - latch A, B and op
  - initial carry = Cin for add, ~Cin for subtract
  - chunk counter = 0
- RUN, each edge:
  - add chunk k of A to chunk k of B' (B' = B for add, ~B for subtract) plus the carry
  - store the chunk sum into the working register; update the carry; increment k
- Last chunk, k = N-1 where N = WIDTH/BITS_PER_CYCLE. On that edge:
  - state goes to IDLE
  - Sum, Cout and Ovf are loaded
  - done=1 for exactly one cycle
- Latency: start is accepted at edge t. done, ready and the new result are visible in the cycle after edge t+N. For WIDTH=8, BITS_PER_CYCLE=1, N=8.
- Arithmetic:
  - add: {Cout,Sum} = A + B + Cin
  - subtract: {Cout,Sum} = A + ~B + ~Cin, i.e. Sum = A - B - Cin mod 2^WIDTH
  - Ovf = carry into MSB XOR carry out of MSB
- Result hold: Sum, Cout and Ovf hold the last result until the next completion. Outputs never show partial sums.
- start while busy (RUN): ignored. No queueing; latched operands are unaffected by input changes.
- Back-to-back: start=1 in the done cycle (ready=1) is accepted on that edge. The next done follows N edges later.
- done is 0 in every cycle except the completion cycle. done never asserts without a preceding accepted start.
- Reset mid-operation: the operation is aborted immediately.
  - Outputs return to reset values; no done pulse.
  - The previous result is lost.
- Inputs are don't-care whenever ready=0 or start=0.

Test Plan:
- WIDTH=8, BPC=1, add A=0xFF, B=0x01, Cin=0 -> done exactly 8 edges after accept; Sum=0x00, Cout=1, Ovf=0, ready=1 with done.
- Add A=0x7F, B=0x01, Cin=0 -> Sum=0x80, Cout=0, Ovf=1. Then subtract A=0x80, B=0x01, Cin=0 -> Sum=0x7F, Cout=1, Ovf=1.
- Subtract A=0x05, B=0x07, Cin=0 -> Sum=0xFE, Cout=0 (borrow), Ovf=0. Then subtract A=0x10, B=0x03, Cin=1 -> Sum=0x0C, Cout=1.
- Start held high during RUN with different operands -> first result unchanged, exactly one done per accepted start. Back-to-back start in the done cycle -> second done 8 edges later.
- Assert rst at the 4th RUN cycle -> ready=1, Sum=0, Cout=0, Ovf=0 immediately, no done. A new add 0x03+0x04 then yields Sum=0x07 after 8 edges.
- WIDTH=4, BPC=2: exhaustive loop over all A, B, Cin, op (1024 cases) -> latency 2 edges each; {Cout,Sum} matches the arithmetic rule; Ovf matches the signed reference model.
